// File: rtl/usb_uart_tx_arbiter.sv
// usb_uart_tx_arbiter: round-robin arbiter sharing the USB serial byte stream among NUM_SRC producers
module usb_uart_tx_arbiter #(
   parameter int NUM_SRC   = 4,
   parameter int MAX_BURST = 16,
   localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                   clk_48mhz,
   input  logic                   reset,
   input  logic [8*NUM_SRC-1:0]   src_data,
   input  logic [NUM_SRC-1:0]     src_valid,
   input  logic [NUM_SRC-1:0]     src_last,
   output logic [NUM_SRC-1:0]     src_ready,
   output logic [7:0]             uart_in_data,
   output logic                   uart_in_valid,
   input  logic                   uart_in_ready,
   output logic [IW-1:0]          grant_id,
   output logic                   busy
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t state, state_d;
   logic [IW-1:0] rr_ptr, rr_d, grant_d, pick, grant_inc;
   logic [7:0] beat_cnt, cnt_d;
   logic found, xfer, done;
   assign busy          = (state == GRANT);
   assign uart_in_valid = busy & src_valid[grant_id];
   assign uart_in_data  = busy ? src_data[int'(grant_id)*8 +: 8] : 8'h00;
   assign src_ready     = busy ? (NUM_SRC'(uart_in_ready) << grant_id) : '0;
   assign xfer          = uart_in_valid & uart_in_ready;
   assign done          = src_last[grant_id] | (beat_cnt == 8'(MAX_BURST-1));
   assign grant_inc     = (grant_id == IW'(NUM_SRC-1)) ? '0 : grant_id + IW'(1);
   // first requester at or after rr_ptr, wrapping modulo NUM_SRC
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      pick  = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_SRC;
         if (!found && src_valid[idx]) begin
            found = 1'b1;
            pick  = IW'(idx);
         end
      end
   end
   // next state: grant on any request in IDLE, release on last beat or burst cap
   always_comb begin
      state_d = state;
      grant_d = grant_id;
      rr_d    = rr_ptr;
      cnt_d   = beat_cnt;
      if (state == IDLE && found) begin
         state_d = GRANT;
         grant_d = pick;
         cnt_d   = 8'd0;
      end else if (state == GRANT && xfer) begin
         state_d = done ? IDLE : GRANT;
         rr_d    = done ? grant_inc : rr_ptr;
         cnt_d   = done ? beat_cnt : beat_cnt + 8'd1;
      end
   end
   // state registers, async reset abandons any frame in flight
   always_ff @(posedge clk_48mhz or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         beat_cnt <= 8'd0;
      end else begin
         state    <= state_d;
         rr_ptr   <= rr_d;
         grant_id <= grant_d;
         beat_cnt <= cnt_d;
      end
   end
endmodule

// File: tb/tb_usb_uart_tx_arbiter.sv
// tb_usb_uart_tx_arbiter: directed vector bench for the USB UART tx arbiter
module tb_usb_uart_tx_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] src_data = '0;
   logic [3:0]  src_valid = '0, src_last = '0, src_ready;
   logic [7:0]  uart_in_data;
   logic        uart_in_valid, uart_in_ready = 1'b1;
   logic [1:0]  grant_id;
   logic        busy;
   int n_cmp = 0, n_err = 0;

   usb_uart_tx_arbiter #(.NUM_SRC(4), .MAX_BURST(16)) dut (
      .clk_48mhz(clk), .reset(reset), .src_data(src_data), .src_valid(src_valid),
      .src_last(src_last), .src_ready(src_ready), .uart_in_data(uart_in_data),
      .uart_in_valid(uart_in_valid), .uart_in_ready(uart_in_ready),
      .grant_id(grant_id), .busy(busy));

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] v, l; logic rdy; logic [31:0] d;
      logic ev; logic [7:0] ed; logic [3:0] er; logic eb; logic [1:0] eg;
   } vec_t;
   vec_t tv[19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic ev, input logic [7:0] ed,
                          input logic [3:0] er, input logic eb, input logic [1:0] eg);
      chk({tag, ".valid"}, 32'(uart_in_valid), 32'(ev));
      chk({tag, ".data"},  32'(uart_in_data),  32'(ed));
      chk({tag, ".ready"}, 32'(src_ready),     32'(er));
      chk({tag, ".busy"},  32'(busy),          32'(eb));
      chk({tag, ".gid"},   32'(grant_id),      32'(eg));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, cyc;
      tv[0]  = '{4'b0001, 4'b0000, 1'b1, 32'h00000041, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
      tv[1]  = '{4'b0001, 4'b0000, 1'b1, 32'h00000041, 1'b1, 8'h41, 4'b0001, 1'b1, 2'd0};
      tv[2]  = '{4'b0001, 4'b0000, 1'b1, 32'h00000042, 1'b1, 8'h42, 4'b0001, 1'b1, 2'd0};
      tv[3]  = '{4'b0001, 4'b0001, 1'b1, 32'h00000043, 1'b1, 8'h43, 4'b0001, 1'b1, 2'd0};
      tv[4]  = '{4'b0000, 4'b0000, 1'b1, 32'h00000000, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
      tv[5]  = '{4'b0101, 4'b0000, 1'b1, 32'h00A000B0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
      tv[6]  = '{4'b0101, 4'b0000, 1'b1, 32'h00A000B0, 1'b1, 8'hA0, 4'b0100, 1'b1, 2'd2};
      tv[7]  = '{4'b0101, 4'b0100, 1'b1, 32'h00A100B0, 1'b1, 8'hA1, 4'b0100, 1'b1, 2'd2};
      tv[8]  = '{4'b0001, 4'b0000, 1'b1, 32'h000000B0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2};
      tv[9]  = '{4'b0001, 4'b0000, 1'b1, 32'h000000B0, 1'b1, 8'hB0, 4'b0001, 1'b1, 2'd0};
      tv[10] = '{4'b0001, 4'b0001, 1'b1, 32'h000000B1, 1'b1, 8'hB1, 4'b0001, 1'b1, 2'd0};
      tv[11] = '{4'b1010, 4'b0000, 1'b1, 32'h00005500, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
      tv[12] = '{4'b1010, 4'b0000, 1'b0, 32'h00005500, 1'b1, 8'h55, 4'b0000, 1'b1, 2'd1};
      tv[13] = '{4'b1010, 4'b0000, 1'b0, 32'h00005500, 1'b1, 8'h55, 4'b0000, 1'b1, 2'd1};
      tv[14] = '{4'b1010, 4'b0010, 1'b1, 32'h00005500, 1'b1, 8'h55, 4'b0010, 1'b1, 2'd1};
      tv[15] = '{4'b1000, 4'b0000, 1'b1, 32'h00000000, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1};
      tv[16] = '{4'b0000, 4'b0000, 1'b1, 32'h00000000, 1'b0, 8'h00, 4'b1000, 1'b1, 2'd3};
      tv[17] = '{4'b1000, 4'b1000, 1'b1, 32'h77000000, 1'b1, 8'h77, 4'b1000, 1'b1, 2'd3};
      tv[18] = '{4'b0000, 4'b0000, 1'b1, 32'h00000000, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd3};

      repeat (3) @(negedge clk);
      #1 chk_all("reset", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
      @(negedge clk);
      reset = 1'b0;

      // table: single frame, contention rotation, ready stall, valid drop
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         src_valid = tv[i].v; src_last = tv[i].l; uart_in_ready = tv[i].rdy; src_data = tv[i].d;
         #1 chk_all($sformatf("vec%0d", i), tv[i].ev, tv[i].ed, tv[i].er, tv[i].eb, tv[i].eg);
      end

      // burst cap: src1 streams 20 bytes, only byte 19 carries last
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      uart_in_ready = 1'b1;
      n = 0;
      for (cyc = 0; cyc < 40 && n < 20; cyc++) begin
         @(negedge clk);
         src_valid = 4'b0010;
         src_data  = 32'(n) << 8;
         src_last  = (n == 19) ? 4'b0010 : 4'b0000;
         #1;
         if (cyc == 17) chk("burst.bubble", 32'(busy), 32'd0);
         if (uart_in_valid && src_ready[1]) begin
            chk($sformatf("burst.cyc%0d", n), 32'(cyc), 32'((n < 16) ? n + 1 : n + 2));
            chk($sformatf("burst.data%0d", n), 32'(uart_in_data), 32'(n));
            n++;
         end
      end
      chk("burst.count", 32'(n), 32'd20);

      // async reset in the middle of a 4-byte frame from src2
      @(negedge clk);
      src_valid = 4'b0100; src_last = 4'b0000; src_data = 32'h00C00000;
      @(negedge clk);
      src_data = 32'h00C10000;
      #1 chk("rst.frame", 32'(uart_in_data), 32'hC1);
      @(negedge clk);
      src_data = 32'h00C20000;
      #2 reset = 1'b1;
      #1 chk_all("rst.async", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
      @(negedge clk);
      reset = 1'b0;
      src_valid = 4'b1111; src_data = 32'h000000D0;
      #1 chk_all("rst.after", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
      @(negedge clk);
      src_last = 4'b0001;
      #1 chk_all("rst.regrant", 1'b1, 8'hD0, 4'b0001, 1'b1, 2'd0);

      // src3 stalls mid-frame while src0 requests; grant is held
      @(negedge clk);
      src_valid = 4'b1000; src_last = 4'b0000; src_data = 32'h30000000;
      @(negedge clk);
      #1 chk_all("stall.first", 1'b1, 8'h30, 4'b1000, 1'b1, 2'd3);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         src_valid = 4'b0001; src_data = 32'h000000E0;
         #1;
         chk($sformatf("stall.busy%0d", i), 32'(busy), 32'd1);
         chk($sformatf("stall.gid%0d", i), 32'(grant_id), 32'd3);
         chk($sformatf("stall.valid%0d", i), 32'(uart_in_valid), 32'd0);
         chk($sformatf("stall.rdy0_%0d", i), 32'(src_ready[0]), 32'd0);
      end
      @(negedge clk);
      src_valid = 4'b1001; src_last = 4'b1000; src_data = 32'h310000E0;
      #1 chk_all("stall.last", 1'b1, 8'h31, 4'b1000, 1'b1, 2'd3);
      @(negedge clk);
      src_valid = 4'b0001; src_last = 4'b0000;
      #1 chk_all("stall.idle", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd3);
      @(negedge clk);
      #1 chk_all("stall.src0", 1'b1, 8'hE0, 4'b0001, 1'b1, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
